// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: FSM encoding,
// default memory map and word-alignment constants.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_DEPTH_WORDS = 64;

  // Byte-offset bits dropped to form a word-aligned address.
  localparam int unsigned ALIGN_BITS = 2;

  function automatic logic [31:0] word_align_mask32();
    return ~((32'd1 << ALIGN_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_addr_map.sv
// Combinational byte-address translation into the memory window plus range
// check; the output offset is word aligned and relative to BASE_ADDR.
module mem_addr_map
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] offset,
  output logic              in_range
);

  // One extra bit so the upper bound cannot wrap for windows near the top.
  localparam logic [DATA_W:0] LO_BOUND = (DATA_W+1)'(BASE_ADDR);
  localparam logic [DATA_W:0] HI_BOUND = (DATA_W+1)'(BASE_ADDR + 4 * DEPTH_WORDS);

  logic [DATA_W:0]   addr_ext;
  logic [DATA_W-1:0] diff;

  assign addr_ext = {1'b0, addr};
  assign in_range = (addr_ext >= LO_BOUND) && (addr_ext < HI_BOUND);
  assign diff     = addr - LO_BOUND[DATA_W-1:0];
  assign offset   = {diff[DATA_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a fixed-latency data memory: latches a load/store,
// holds it for WAIT_CYCLES cycles and stalls the pipeline through ready.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              wr_reg;
  logic              conflict_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic              req_any;
  logic              last_cycle;
  logic [DATA_W-1:0] map_offset;
  logic              map_in_range;

  mem_addr_map #(
    .DATA_W      (DATA_W),
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_addr_map (
    .addr     (req_addr),
    .offset   (map_offset),
    .in_range (map_in_range)
  );

  assign req_any    = req_rd | req_wr;
  assign last_cycle = (state_reg == ST_ACCESS) && (cnt_reg == CNT_LAST);
  assign rdata      = rdata_reg;
  assign err        = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wr_reg       <= 1'b0;
      conflict_reg <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && req_any) begin
        addr_reg     <= map_offset;
        wdata_reg    <= req_wdata;
        // A simultaneous rd+wr is carried out as a store and flagged later.
        wr_reg       <= req_wr;
        conflict_reg <= req_rd & req_wr;
        if (!map_in_range) begin
          err_reg <= 1'b1;
        end
      end
      if (last_cycle) begin
        if (!wr_reg) begin
          rdata_reg <= mem_rdata;
        end
        err_reg <= conflict_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_reg)
      ST_IDLE: begin
        ready = ~req_any;
        if (req_any) begin
          cnt_next   = '0;
          state_next = map_in_range ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        mem_addr = addr_reg;
        if (wr_reg) begin
          mem_wdata = wdata_reg;
          // Single write edge: only the final access cycle enables the write.
          mem_w_en  = last_cycle;
        end else begin
          mem_r_en = 1'b1;
        end
        if (last_cycle) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        ready      = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
